// File: rtl/ascon_pkg.sv
// ascon_pkg: shared state type, round constants, rotation amounts and FSM encoding for the Ascon permutation
package ascon_pkg;
    localparam int NUM_WORDS  = 5;
    localparam int WORD_WIDTH = 64;
    localparam int MAX_ROUNDS = 12;
    typedef logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] ascon_state_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} perm_fsm_e;
    localparam logic [7:0] ROUND_CONST [0:MAX_ROUNDS-1] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };
    localparam int ROT_A [0:NUM_WORDS-1] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [0:NUM_WORDS-1] = '{28, 39, 6, 17, 41};
    function automatic logic [WORD_WIDTH-1:0] ror(input logic [WORD_WIDTH-1:0] x, input int n);
        return (x >> n) | (x << (WORD_WIDTH - n));
    endfunction
endpackage

// File: rtl/ascon_round.sv
// ascon_round: one combinational Ascon round (constant addition, S-box layer, linear diffusion)
module ascon_round
    import ascon_pkg::*;
(
    input  ascon_state_t state_i,
    input  logic [3:0]   round_idx_i,
    output ascon_state_t state_o
);
    ascon_state_t c_add, s_out;
    logic [7:0]   rc;
    // indices past the last round only occur while idle and are harmless
    assign rc = (round_idx_i < 4'(MAX_ROUNDS)) ? ROUND_CONST[round_idx_i] : 8'h00;
    always_comb begin
        c_add = state_i;
        c_add[2][7:0] = state_i[2][7:0] ^ rc;
    end
    substitution_layer u_sub (
        .state_i (c_add),
        .state_o (s_out)
    );
    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_lin
        assign state_o[w] = s_out[w] ^ ror(s_out[w], ROT_A[w]) ^ ror(s_out[w], ROT_B[w]);
    end
endmodule

// File: rtl/substitution_layer.sv
// substitution_layer: bit-sliced 5-bit Ascon S-box applied to all 64 columns at once
module substitution_layer
    import ascon_pkg::*;
(
    input  ascon_state_t state_i,
    output ascon_state_t state_o
);
    logic [WORD_WIDTH-1:0] x0, x1, x2, x3, x4;
    logic [WORD_WIDTH-1:0] y0, y1, y2, y3, y4;
    assign x0 = state_i[0] ^ state_i[4];
    assign x1 = state_i[1];
    assign x2 = state_i[2] ^ state_i[1];
    assign x3 = state_i[3];
    assign x4 = state_i[4] ^ state_i[3];
    // non-linear chi step, then the affine output mixing
    assign y0 = x0 ^ (~x1 & x2);
    assign y1 = x1 ^ (~x2 & x3);
    assign y2 = x2 ^ (~x3 & x4);
    assign y3 = x3 ^ (~x4 & x0);
    assign y4 = x4 ^ (~x0 & x1);
    assign state_o[0] = y0 ^ y4;
    assign state_o[1] = y1 ^ y0;
    assign state_o[2] = ~y2;
    assign state_o[3] = y3 ^ y2;
    assign state_o[4] = y4;
endmodule

// File: rtl/ascon_permutation_ctrl.sv
// ascon_permutation_ctrl: iterative Ascon-p[rnd] engine, UNROLL rounds per clock
// between a request and a result valid/ready handshake.
module ascon_permutation_ctrl
    import ascon_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [3:0]   rounds_i,
    input  ascon_state_t state_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output ascon_state_t state_o,
    output logic         err_o,
    output logic         busy_o
);
    if (UNROLL < 1 || UNROLL > 3) begin : g_bad_unroll
        $error("ascon_permutation_ctrl: UNROLL must be 1, 2 or 3");
    end

    perm_fsm_e    fsm_q, fsm_d;
    ascon_state_t state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         err_q, err_d;
    logic         legal;
    ascon_state_t chain [0:UNROLL];

    assign chain[0] = state_q;
    for (genvar k = 0; k < UNROLL; k++) begin : g_rnd
        ascon_round u_round (
            .state_i     (chain[k]),
            .round_idx_i (rnd_q + 4'(k)),
            .state_o     (chain[k+1])
        );
    end

    assign legal = (rounds_i != 4'd0) && (rounds_i <= 4'(MAX_ROUNDS))
                   && ((rounds_i % 4'(UNROLL)) == 4'd0);

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rnd_d   = rnd_q;
        err_d   = 1'b0;
        case (fsm_q)
            IDLE: if (in_valid_i) begin
                if (legal) begin
                    state_d = state_i;
                    rnd_d   = 4'(MAX_ROUNDS) - rounds_i;
                    fsm_d   = RUN;
                end else begin
                    err_d = 1'b1;
                end
            end
            RUN: begin
                state_d = chain[UNROLL];
                rnd_d   = rnd_q + 4'(UNROLL);
                fsm_d   = (rnd_d == 4'(MAX_ROUNDS)) ? DONE : RUN;
            end
            DONE: fsm_d = out_ready_i ? IDLE : DONE;
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rnd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rnd_q   <= rnd_d;
            err_q   <= err_d;
        end
    end

    assign in_ready_o  = (fsm_q == IDLE);
    assign out_valid_o = (fsm_q == DONE);
    assign busy_o      = (fsm_q != IDLE);
    assign state_o     = state_q;
    assign err_o       = err_q;
endmodule
